// File: rtl/serial_to_parallel_if.sv
// Handshake bundle between a serial link front end and the deserializer.
// The slave modport is the deserializer's view; master is the link/consumer side.
interface serial_to_parallel_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             sen;
    logic             sin;
    logic             ack;
    logic [WIDTH-1:0] A;
    logic             valid;
    logic             busy;
    logic             overrun;

    modport master (
        output start, sen, sin, ack,
        input  A, valid, busy, overrun
    );

    modport slave (
        input  start, sen, sin, ack,
        output A, valid, busy, overrun
    );
endinterface

// File: rtl/serial_to_parallel.sv
// Assembles a start-delimited, strobe-qualified serial bit stream into a
// WIDTH-bit word and presents it on A with a valid/ack handshake.
module serial_to_parallel #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    serial_to_parallel_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            a_q     <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            a_q     <= a_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], bus.sin} : {bus.sin, sr_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        a_d     = a_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (valid_q && bus.ack) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            SHIFT: begin
                if (bus.start) begin
                    cnt_d = '0;
                    sr_d  = '0;
                end else if (bus.sen) begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        // Completed word: accepted if the slot is free or being freed this edge.
                        state_d = IDLE;
                        cnt_d   = '0;
                        sr_d    = '0;
                        if (!valid_q || bus.ack) begin
                            a_d     = shifted;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        sr_d  = shifted;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.A       = a_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = (state_q == SHIFT);
    assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_serial_to_parallel.sv
// Drives an MSB-first and an LSB-first deserializer with identical stimulus and
// checks both against a bit-queue reference model.
module tb_serial_to_parallel;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_to_parallel_if #(.WIDTH(W)) bm ();
    serial_to_parallel_if #(.WIDTH(W)) bl ();

    serial_to_parallel #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(bm));
    serial_to_parallel #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(bl));

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: frame bits in arrival order, placed into the word at completion.
    logic         m_frame = 1'b0;
    logic         m_bits[$];
    logic [W-1:0] m_a_msb = '0;
    logic [W-1:0] m_a_lsb = '0;
    logic         m_valid = 1'b0;
    logic         m_ovr = 1'b0;

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < int'(W); i++) r[i] = x[W-1-i];
        return r;
    endfunction

    task automatic cycle(input logic r, input logic s, input logic e, input logic d, input logic k);
        logic nvalid;
        logic [W-1:0] wm, wl;
        rst = r;
        bm.start = s; bm.sen = e; bm.sin = d; bm.ack = k;
        bl.start = s; bl.sen = e; bl.sin = d; bl.ack = k;
        @(posedge clk);
        if (r) begin
            m_frame = 1'b0; m_bits.delete();
            m_a_msb = '0; m_a_lsb = '0; m_valid = 1'b0; m_ovr = 1'b0;
        end else begin
            nvalid = (m_valid && k) ? 1'b0 : m_valid;
            if (s) begin
                m_frame = 1'b1;
                m_bits.delete();
            end else if (m_frame && e) begin
                m_bits.push_back(d);
                if (m_bits.size() == int'(W)) begin
                    for (int i = 0; i < int'(W); i++) begin
                        wm[W-1-i] = m_bits[i];
                        wl[i]     = m_bits[i];
                    end
                    m_frame = 1'b0;
                    m_bits.delete();
                    if (!m_valid || k) begin
                        m_a_msb = wm; m_a_lsb = wl; nvalid = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
            end
            m_valid = nvalid;
        end
        #1;
    endtask

    task automatic idle(input logic k);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, k);
    endtask

    // seq[W-1] is the first bit on the wire.
    task automatic frame(input logic [W-1:0] seq, input int gap, input logic ack_last);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = W - 1; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) idle(1'b0);
            cycle(1'b0, 1'b0, 1'b1, seq[i], (i == 0) ? ack_last : 1'b0);
        end
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if ({bm.A, bl.A, bm.valid, bm.busy, bm.overrun, bl.valid, bl.busy, bl.overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got A=%b/%b v=%b b=%b o=%b, required all zero",
                     bm.A, bl.A, bm.valid, bm.busy, bm.overrun);
        end
    endtask

    task automatic test_basic;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bm.busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_busy_after_start: got %b required 1", bm.busy);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bm.valid !== 1'b0 || bm.A !== 4'b0000) begin
            n_fail++; $display("FAIL basic_no_partial: got A=%b v=%b required 0000/0", bm.A, bm.valid);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bm.A !== 4'b1010 || bm.valid !== 1'b1 || bm.busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_word: got A=%b v=%b b=%b required 1010/1/0", bm.A, bm.valid, bm.busy);
        end
        n_cmp++;
        if (bl.A !== 4'b0101) begin
            n_fail++; $display("FAIL basic_word_lsb: got %b required 0101", bl.A);
        end
        idle(1'b1);
        n_cmp++;
        if (bm.valid !== 1'b0 || bm.A !== 4'b1010) begin
            n_fail++; $display("FAIL basic_ack: got A=%b v=%b required 1010/0", bm.A, bm.valid);
        end
        idle(1'b1);
        n_cmp++;
        if (bm.valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_ack_idle: got v=%b required 0", bm.valid);
        end
    endtask

    task automatic test_gaps;
        logic [W-1:0] seq;
        seq = 4'b0110;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = W - 1; i >= 0; i--) begin
            idle(1'b0);
            idle(1'b0);
            cycle(1'b0, 1'b0, 1'b1, seq[i], 1'b0);
            if (i != 0) begin
                n_cmp++;
                if (bm.A !== 4'b1010 || bm.valid !== 1'b0 || bm.busy !== 1'b1) begin
                    n_fail++; $display("FAIL gaps_hold_%0d: got A=%b v=%b b=%b required 1010/0/1", i, bm.A, bm.valid, bm.busy);
                end
            end
        end
        n_cmp++;
        if (bm.A !== 4'b0110 || bm.valid !== 1'b1 || bl.A !== 4'b0110) begin
            n_fail++; $display("FAIL gaps_word: got A=%b/%b v=%b required 0110/0110/1", bm.A, bl.A, bm.valid);
        end
        idle(1'b1);
    endtask

    task automatic test_overrun;
        frame(4'b1010, 0, 1'b0);
        frame(4'b0011, 0, 1'b0);
        n_cmp++;
        if (bm.A !== 4'b1010 || bm.valid !== 1'b1 || bm.overrun !== 1'b1) begin
            n_fail++; $display("FAIL overrun_drop: got A=%b v=%b o=%b required 1010/1/1", bm.A, bm.valid, bm.overrun);
        end
        idle(1'b1);
        idle(1'b0);
        n_cmp++;
        if (bm.valid !== 1'b0 || bm.overrun !== 1'b1 || bl.overrun !== 1'b1) begin
            n_fail++; $display("FAIL overrun_sticky: got v=%b o=%b/%b required 0/1/1", bm.valid, bm.overrun, bl.overrun);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bm.overrun !== 1'b0 || bm.A !== 4'b0000) begin
            n_fail++; $display("FAIL overrun_reset: got o=%b A=%b required 0/0000", bm.overrun, bm.A);
        end
    endtask

    task automatic test_ack_same;
        frame(4'b1010, 0, 1'b0);
        frame(4'b1100, 1, 1'b1);
        n_cmp++;
        if (bm.A !== 4'b1100 || bm.valid !== 1'b1 || bm.overrun !== 1'b0 || bl.A !== 4'b0011) begin
            n_fail++; $display("FAIL ack_same_cycle: got A=%b/%b v=%b o=%b required 1100/0011/1/0",
                               bm.A, bl.A, bm.valid, bm.overrun);
        end
        idle(1'b1);
    endtask

    task automatic test_restart;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        // Start coincident with a strobe: start wins and the strobe carries no data.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bm.valid !== 1'b0 || bm.busy !== 1'b1) begin
            n_fail++; $display("FAIL restart_partial: got v=%b b=%b required 0/1", bm.valid, bm.busy);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bm.A !== 4'b0101 || bm.valid !== 1'b1 || bl.A !== 4'b1010) begin
            n_fail++; $display("FAIL restart_word: got A=%b/%b v=%b required 0101/1010/1", bm.A, bl.A, bm.valid);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({bm.A, bm.valid, bm.busy, bm.overrun} !== '0) begin
            n_fail++; $display("FAIL restart_reset: got A=%b v=%b b=%b o=%b required all zero",
                               bm.A, bm.valid, bm.busy, bm.overrun);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bm.valid !== 1'b0 || bm.busy !== 1'b0 || bm.A !== 4'b0000) begin
            n_fail++; $display("FAIL idle_ignores_sen: got A=%b v=%b b=%b required 0000/0/0", bm.A, bm.valid, bm.busy);
        end
    endtask

    task automatic test_lsb_first;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(4'b1000, 0, 1'b0);
        n_cmp++;
        if (bl.A !== 4'b0001 || bl.valid !== 1'b1) begin
            n_fail++; $display("FAIL lsb_first_word: got A=%b v=%b required 0001/1", bl.A, bl.valid);
        end
        n_cmp++;
        if (bm.A !== 4'b1000) begin
            n_fail++; $display("FAIL lsb_first_msb_ref: got %b required 1000", bm.A);
        end
    endtask

    task automatic test_random;
        logic r, s, e, d, k;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 2) != 0);
            d = 1'($urandom);
            k = ($urandom_range(0, 5) == 0);
            cycle(r, s, e, d, k);
            n_cmp++;
            if (bm.A !== m_a_msb || bl.A !== m_a_lsb || bm.valid !== m_valid || bl.valid !== m_valid ||
                bm.busy !== m_frame || bl.busy !== m_frame || bm.overrun !== m_ovr || bl.overrun !== m_ovr) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got A=%b/%b v=%b b=%b o=%b required A=%b/%b v=%b b=%b o=%b",
                         n, bm.A, bl.A, bm.valid, bm.busy, bm.overrun, m_a_msb, m_a_lsb, m_valid, m_frame, m_ovr);
            end
        end
    endtask

    initial begin
        bm.start = 1'b0; bm.sen = 1'b0; bm.sin = 1'b0; bm.ack = 1'b0;
        bl.start = 1'b0; bl.sen = 1'b0; bl.sin = 1'b0; bl.ack = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_ack_same();
        test_restart();
        test_lsb_first();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
